// File: rtl/rat_pkg.sv
// rtl/rat_pkg.sv - shared types and sizes for the RAT checkpoint controller
package rat_pkg;

    localparam int NUM_PAGES = 32;
    localparam int PAGE_W    = 5;
    localparam int CNT_W     = 6;

    typedef logic [PAGE_W-1:0] page_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ckpt_state_e;

endpackage

// File: rtl/ckpt_page_queue.sv
// rtl/ckpt_page_queue.sv - circular checkpoint page queue with alloc, retire and truncate
module ckpt_page_queue
    import rat_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 alloc_i,
    input  logic                 set_done_i,
    input  logic [PAGE_W-1:0]    done_page_i,
    input  logic                 trunc_i,
    input  logic [PAGE_W-1:0]    trunc_page_i,
    output logic [PAGE_W-1:0]    head_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [NUM_PAGES-1:0] live_o
);

    page_t                 head_q, head_d, tail_q, tail_d, trunc_pos;
    cnt_t                  count_q, count_d;
    logic [NUM_PAGES-1:0]  live_q, live_d, done_q, done_d;
    logic                  retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        live_d    = live_q;
        done_d    = done_q;
        trunc_pos = trunc_page_i - tail_q;
        // A truncate that lands on the tail frees it, so it must not also retire
        retire    = live_q[tail_q] & done_q[tail_q] & ~(trunc_i & (trunc_page_i == tail_q));
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            live_d  = '0;
            done_d  = '0;
        end else begin
            if (set_done_i) begin
                done_d[done_page_i] = 1'b1;
            end
            if (retire) begin
                live_d[tail_q] = 1'b0;
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + page_t'(1);
            end
            if (trunc_i) begin
                for (int i = 0; i < NUM_PAGES; i++) begin
                    if (page_t'(page_t'(i) - tail_q) >= trunc_pos) begin
                        live_d[i] = 1'b0;
                        done_d[i] = 1'b0;
                    end
                end
                head_d  = trunc_page_i;
                count_d = cnt_t'(page_t'(trunc_page_i - tail_d));
            end else begin
                if (alloc_i) begin
                    live_d[head_q] = 1'b1;
                    done_d[head_q] = 1'b0;
                    head_d         = head_q + page_t'(1);
                end
                count_d = count_q + cnt_t'(alloc_i) - cnt_t'(retire);
            end
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign live_o  = live_q;

endmodule

// File: rtl/rat_checkpoint_ctrl.sv
// rtl/rat_checkpoint_ctrl.sv - RAT checkpoint page allocator/recovery control
// Optional statistics counters are built when RAT_CKPT_STATS_EN is defined.
module rat_checkpoint_ctrl
    import rat_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              br_alloc_req,
    input  logic              br_resolve_valid,
    input  logic [PAGE_W-1:0] br_resolve_page,
    input  logic              br_mispredict,
    input  logic              exception_sig,
    input  logic              mret_sig,
    output logic              save_state,
    output logic [PAGE_W-1:0] save_page,
    output logic              restore_state,
    output logic [PAGE_W-1:0] restore_page,
    output logic              ckpt_stall,
    output logic [CNT_W-1:0]  ckpt_count
`ifdef RAT_CKPT_STATS_EN
    ,
    output logic [15:0]       stat_mispredicts,
    output logic [15:0]       stat_full_cycles
`endif
);

    ckpt_state_e          state_q, state_d;
    page_t                head;
    cnt_t                 count;
    logic [NUM_PAGES-1:0] live;
    logic                 flush, full, live_hit, mispredict_hit, correct_hit, alloc;

    assign flush    = exception_sig | mret_sig;
    assign full     = (count == cnt_t'(NUM_PAGES));
    assign live_hit = live[br_resolve_page];

    ckpt_page_queue u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush),
        .alloc_i      (alloc),
        .set_done_i   (correct_hit),
        .done_page_i  (br_resolve_page),
        .trunc_i      (mispredict_hit),
        .trunc_page_i (br_resolve_page),
        .head_o       (head),
        .count_o      (count),
        .live_o       (live)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        if (!flush && mispredict_hit) begin
            state_d = RECOVER;
        end
    end

    // Flush and reset suppress every RAT-facing strobe in the same cycle
    always_comb begin
        mispredict_hit = ~reset & ~flush & br_resolve_valid & br_mispredict & live_hit;
        correct_hit    = ~reset & ~flush & br_resolve_valid & ~br_mispredict & live_hit;
        alloc          = ~reset & ~flush & br_alloc_req & ~full & ~mispredict_hit & (state_q == RUN);
        save_state     = alloc;
        save_page      = head;
        restore_state  = mispredict_hit;
        restore_page   = mispredict_hit ? br_resolve_page : '0;
        ckpt_stall     = full | (state_q == RECOVER) | mispredict_hit;
        ckpt_count     = count;
    end

`ifdef RAT_CKPT_STATS_EN
    logic [15:0] stat_mis_q, stat_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_mis_q  <= '0;
            stat_full_q <= '0;
        end else begin
            if (mispredict_hit && (stat_mis_q != 16'hFFFF)) begin
                stat_mis_q <= stat_mis_q + 16'd1;
            end
            if (br_alloc_req && full && (stat_full_q != 16'hFFFF)) begin
                stat_full_q <= stat_full_q + 16'd1;
            end
        end
    end

    assign stat_mispredicts = stat_mis_q;
    assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: tb/tb_rat_checkpoint_ctrl.sv
// tb/tb_rat_checkpoint_ctrl.sv - vector table, corner sequences and random model check for rat_checkpoint_ctrl
module tb_rat_checkpoint_ctrl;

    logic       clk, reset;
    logic       req, rv, mis, exc, mret;
    logic [4:0] rpage;
    logic       save_state, restore_state, ckpt_stall;
    logic [4:0] save_page, restore_page;
    logic [5:0] ckpt_count;
`ifdef RAT_CKPT_STATS_EN
    logic [15:0] stat_mispredicts, stat_full_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rat_checkpoint_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .br_alloc_req     (req),
        .br_resolve_valid (rv),
        .br_resolve_page  (rpage),
        .br_mispredict    (mis),
        .exception_sig    (exc),
        .mret_sig         (mret),
        .save_state       (save_state),
        .save_page        (save_page),
        .restore_state    (restore_state),
        .restore_page     (restore_page),
        .ckpt_stall       (ckpt_stall),
        .ckpt_count       (ckpt_count)
`ifdef RAT_CKPT_STATS_EN
        ,
        .stat_mispredicts (stat_mispredicts),
        .stat_full_cycles (stat_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r; bit v; int p; bit m; bit e;
        bit e_save; int e_spage; bit e_rest; int e_rpage; bit e_stall; int e_cnt;
    } rec_t;
    rec_t tbl[25];

    typedef struct { int page; bit done; } ent_t;
    ent_t mq[$];
    int   mhead;
    bit   mrec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int p, input bit m, input bit e, input bit t);
        @(posedge clk);
        #1;
        req = r; rv = v; rpage = 5'(p); mis = m; exc = e; mret = t;
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0, 1,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0, 1,1,0,0,0,1};
        tbl[2]  = '{1,0,0,0,0, 1,2,0,0,0,2};
        tbl[3]  = '{0,0,0,0,0, 0,3,0,0,0,3};
        tbl[4]  = '{0,1,0,0,0, 0,3,0,0,0,3};
        tbl[5]  = '{0,1,2,0,0, 0,3,0,0,0,3};
        tbl[6]  = '{0,0,0,0,0, 0,3,0,0,0,2};
        tbl[7]  = '{0,0,0,0,0, 0,3,0,0,0,2};
        tbl[8]  = '{0,1,1,0,0, 0,3,0,0,0,2};
        tbl[9]  = '{0,0,0,0,0, 0,3,0,0,0,2};
        tbl[10] = '{0,0,0,0,0, 0,3,0,0,0,1};
        tbl[11] = '{0,0,0,0,0, 0,3,0,0,0,0};
        tbl[12] = '{0,0,0,0,1, 0,3,0,0,0,0};
        tbl[13] = '{1,0,0,0,0, 1,0,0,0,0,0};
        tbl[14] = '{1,0,0,0,0, 1,1,0,0,0,1};
        tbl[15] = '{1,0,0,0,0, 1,2,0,0,0,2};
        tbl[16] = '{1,0,0,0,0, 1,3,0,0,0,3};
        tbl[17] = '{1,0,0,0,0, 1,4,0,0,0,4};
        tbl[18] = '{0,1,2,1,0, 0,5,1,2,1,5};
        tbl[19] = '{1,0,0,0,0, 0,2,0,0,1,2};
        tbl[20] = '{1,0,0,0,0, 1,2,0,0,0,2};
        tbl[21] = '{0,0,0,0,0, 0,3,0,0,0,3};
        tbl[22] = '{1,1,1,1,1, 0,3,0,0,0,3};
        tbl[23] = '{1,0,0,0,0, 1,0,0,0,0,0};
        tbl[24] = '{0,0,0,0,0, 0,1,0,0,0,1};

        reset = 1'b1; req = 1'b1; rv = 1'b1; rpage = '0; mis = 1'b1; exc = 1'b0; mret = 1'b0;
        @(negedge clk);
        chk("reset save_state", save_state, 0);
        chk("reset save_page", save_page, 0);
        chk("reset restore_state", restore_state, 0);
        chk("reset restore_page", restore_page, 0);
        chk("reset stall", ckpt_stall, 0);
        chk("reset count", ckpt_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; req = 1'b0; rv = 1'b0; mis = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].m, tbl[i].e, 1'b0);
            chk($sformatf("row%0d save_state", i), save_state, tbl[i].e_save);
            chk($sformatf("row%0d save_page", i), save_page, tbl[i].e_spage);
            chk($sformatf("row%0d restore_state", i), restore_state, tbl[i].e_rest);
            chk($sformatf("row%0d restore_page", i), restore_page, tbl[i].e_rpage);
            chk($sformatf("row%0d stall", i), ckpt_stall, tbl[i].e_stall);
            chk($sformatf("row%0d count", i), ckpt_count, tbl[i].e_cnt);
        end

        // Fill all pages, then free page 0 and watch the allocator wrap
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk($sformatf("fill%0d save_page", i), save_page, i);
            chk($sformatf("fill%0d save_state", i), save_state, 1);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("full count", ckpt_count, 32);
        chk("full stall", ckpt_stall, 1);
        chk("full save blocked", save_state, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("full resolve count", ckpt_count, 32);
        step(0, 0, 0, 0, 0, 0);
        chk("full retire pending count", ckpt_count, 32);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap count", ckpt_count, 31);
        chk("wrap stall", ckpt_stall, 0);
        chk("wrap save_state", save_state, 1);
        chk("wrap save_page", save_page, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("refull count", ckpt_count, 32);
        chk("refull stall", ckpt_stall, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("mret save blocked", save_state, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("mret count", ckpt_count, 0);
        chk("mret save_page", save_page, 0);

        // Random traffic against an in-order queue model of live branches
        mq.delete(); mhead = 0; mrec = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int  idx, sel;
            bit  fl, hit, chit, full, alloc, ret;
            @(posedge clk);
            #1;
            req  = ($urandom_range(0, 3) != 0);
            rv   = $urandom_range(0, 1);
            mis  = ($urandom_range(0, 5) == 0);
            exc  = (c == 0) || ($urandom_range(0, 99) == 0);
            mret = ($urandom_range(0, 149) == 0);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                sel   = $urandom_range(0, 1) ? 0 : $urandom_range(0, mq.size() - 1);
                rpage = 5'(mq[sel].page);
            end else begin
                rpage = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            idx = -1;
            foreach (mq[k]) if (mq[k].page == int'(rpage)) idx = k;
            fl    = exc | mret;
            hit   = !fl && rv && mis && idx >= 0;
            chit  = !fl && rv && !mis && idx >= 0;
            full  = (mq.size() == 32);
            alloc = !fl && req && !full && !hit && !mrec;
            chk("rnd save_state", save_state, alloc);
            if (alloc) chk("rnd save_page", save_page, mhead);
            chk("rnd restore_state", restore_state, hit);
            if (hit) chk("rnd restore_page", restore_page, rpage);
            chk("rnd stall", ckpt_stall, full || mrec || hit);
            chk("rnd count", ckpt_count, mq.size());
            if (fl) begin
                mq.delete(); mhead = 0; mrec = 1'b0;
            end else begin
                ret = mq.size() > 0 && mq[0].done && !(hit && idx == 0);
                if (hit) begin
                    while (mq.size() > idx) void'(mq.pop_back());
                    mhead = int'(rpage);
                end
                if (ret) void'(mq.pop_front());
                if (chit && !(ret && idx == 0)) mq[ret ? idx - 1 : idx].done = 1'b1;
                if (alloc) begin
                    mq.push_back('{mhead, 1'b0});
                    mhead = (mhead + 1) % 32;
                end
                mrec = hit;
            end
        end

`ifdef RAT_CKPT_STATS_EN
        @(posedge clk);
        #1;
        reset = 1'b1; req = 1'b0; rv = 1'b0; mis = 1'b0; exc = 1'b0; mret = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 36; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 31, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 30, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 29, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("stat_mispredicts", stat_mispredicts, 3);
        chk("stat_full_cycles", stat_full_cycles, 4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("stat_full_cycles saturate", stat_full_cycles, 16'hFFFF);
        chk("stat_mispredicts after flush", stat_mispredicts, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
